// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART receive controller.
package uart_pkg;
  typedef enum logic [1:0] {OFF, RUN, FLUSH} rx_ctrl_state_e;
  localparam int RX_DATA_W = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_RTS_HI = 14;
  localparam int RX_RTS_LO = 8;
  localparam int RX_TIMEOUT_TICKS = 640;
  typedef struct packed {
    logic perr;
    logic [RX_DATA_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receiver character input and FIFO read/status bundle.
interface uart_rx_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CW = 5
);
  logic rx_done_i;
  logic [DATA_W-1:0] rx_data_i;
  logic parity_error_i;
  logic rd_en_i;
  logic [DATA_W-1:0] rd_data_o;
  logic rd_perr_o;
  logic [CW-1:0] count_o;
  logic empty_o;
  logic full_o;
  modport master (
    output rx_done_i, rx_data_i, parity_error_i, rd_en_i,
    input rd_data_o, rd_perr_o, count_o, empty_o, full_o
  );
  modport slave (
    input rx_done_i, rx_data_i, parity_error_i, rd_en_i,
    output rd_data_o, rd_perr_o, count_o, empty_o, full_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO; a push into a full FIFO is taken only alongside a pop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter type entry_t = rx_entry_t,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  entry_t din,
  output entry_t dout,
  output logic [CW-1:0] count,
  output logic empty,
  output logic full
);
  entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = clear ? '0 : wr_q + AW'(do_push);
    rd_d = clear ? '0 : rd_q + AW'(do_pop);
    cnt_d = clear ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive FIFO, sticky status, RTS hysteresis and interrupt for the UART receiver.
// Optional idle timeout built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = RX_FIFO_DEPTH,
  parameter int DATA_W = RX_DATA_W,
  parameter int RTS_HI = RX_RTS_HI,
  parameter int RTS_LO = RX_RTS_LO,
  parameter int TIMEOUT_TICKS = RX_TIMEOUT_TICKS,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_en_i,
  input  logic flush_i,
  input  logic rx_tick_i,
  input  logic [CW-1:0] fifo_thr_i,
  input  logic clr_overrun_i,
  input  logic clr_perr_i,
  output logic overrun_o,
  output logic parity_err_o,
  output logic timeout_o,
  output logic irq_o,
  output logic rts_n_o,
  uart_rx_ctrl_if.slave bus
);
  typedef struct packed {
    logic perr;
    logic [DATA_W-1:0] data;
  } entry_t;
  rx_ctrl_state_e state_q, state_d;
  logic overrun_q, overrun_d, perr_q, perr_d, rts_q, rts_d;
  logic push, pop;
  entry_t din, head;
  logic [CW-1:0] thr;
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .clear(state_q == FLUSH),
    .din(din),
    .dout(head),
    .count(bus.count_o),
    .empty(bus.empty_o),
    .full(bus.full_o)
  );
  always_comb begin
    state_d = flush_i ? FLUSH : rx_en_i ? RUN : OFF;
    push = (state_q == RUN) & bus.rx_done_i;
    pop = bus.rd_en_i & (state_q != FLUSH);
    din = '{perr: bus.parity_error_i, data: bus.rx_data_i};
    // a pop from a full FIFO always succeeds, so it alone rescues the push
    overrun_d = (push & bus.full_o & ~pop) | (overrun_q & ~clr_overrun_i);
    perr_d = (push & bus.parity_error_i) | (perr_q & ~clr_perr_i);
    rts_d = (state_q == OFF) | (bus.count_o >= CW'(RTS_HI)) | (rts_q & (bus.count_o >= CW'(RTS_LO)));
    thr = (fifo_thr_i == '0) ? CW'(1) : fifo_thr_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      overrun_q <= 1'b0;
      perr_q <= 1'b0;
      rts_q <= 1'b1;
    end else begin
      state_q <= state_d;
      overrun_q <= overrun_d;
      perr_q <= perr_d;
      rts_q <= rts_d;
    end
  end
`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic timeout_q, timeout_d, do_pop;
  always_comb begin
    do_pop = pop & ~bus.empty_o;
    tcnt_d = (state_q != RUN || bus.empty_o || push || do_pop) ? '0 :
             (rx_tick_i && tcnt_q != TW'(TIMEOUT_TICKS)) ? tcnt_q + 1'b1 : tcnt_q;
    timeout_d = (do_pop || state_q == FLUSH) ? 1'b0 :
                (tcnt_d == TW'(TIMEOUT_TICKS)) ? 1'b1 : timeout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = rx_tick_i ^ (TIMEOUT_TICKS == 0);
  assign timeout_o = 1'b0;
`endif
  assign bus.rd_data_o = head.data;
  assign bus.rd_perr_o = head.perr;
  assign overrun_o = overrun_q;
  assign parity_err_o = perr_q;
  assign rts_n_o = rts_q;
  assign irq_o = (bus.count_o >= thr) | overrun_q | perr_q | timeout_o;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed self-checking bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;
  logic clk = 1'b0, rst = 1'b1, rx_en = 1'b0, flush = 1'b0, tick = 1'b0;
  logic clr_ovr = 1'b0, clr_perr = 1'b0;
  logic [4:0] thr = 5'd16;
  logic ovr, perr, tmo, irq, rts;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_rx_ctrl_if #(.DATA_W(8), .CW(5)) bus ();
  uart_rx_ctrl dut (
    .clk(clk),
    .rst(rst),
    .rx_en_i(rx_en),
    .flush_i(flush),
    .rx_tick_i(tick),
    .fifo_thr_i(thr),
    .clr_overrun_i(clr_ovr),
    .clr_perr_i(clr_perr),
    .overrun_o(ovr),
    .parity_err_o(perr),
    .timeout_o(tmo),
    .irq_o(irq),
    .rts_n_o(rts),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic p);
    bus.rx_done_i = 1'b1;
    bus.rx_data_i = d;
    bus.parity_error_i = p;
    cyc(1);
    bus.rx_done_i = 1'b0;
    bus.parity_error_i = 1'b0;
  endtask
  task automatic pop();
    bus.rd_en_i = 1'b1;
    cyc(1);
    bus.rd_en_i = 1'b0;
  endtask
  initial begin
    bus.rx_done_i = 1'b0;
    bus.rx_data_i = '0;
    bus.parity_error_i = 1'b0;
    bus.rd_en_i = 1'b0;
    cyc(2);
    rst = 1'b0;
    check("rst_count", bus.count_o, 0);
    check("rst_empty", bus.empty_o, 1);
    check("rst_full", bus.full_o, 0);
    check("rst_ovr", ovr, 0);
    check("rst_perr", perr, 0);
    check("rst_tmo", tmo, 0);
    check("rst_irq", irq, 0);
    check("rst_rts", rts, 1);
    send(8'h99, 1'b0);
    check("off_discard", bus.count_o, 0);
    check("off_no_perr", perr, 0);
    rx_en = 1'b1;
    cyc(1);
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    check("three_count", bus.count_o, 3);
    check("three_rts", rts, 0);
    for (int i = 0; i < 3; i++) begin
      check("order_head", bus.rd_data_o, 32'h41 + i);
      pop();
    end
    check("order_empty", bus.empty_o, 1);
    for (int k = 1; k <= 17; k++) begin
      send(8'h10 + 8'(k - 1), 1'b0);
      if (k == 14) check("rts_lag14", rts, 0);
      if (k == 15) check("rts_hi", rts, 1);
    end
    check("ovf_count", bus.count_o, 16);
    check("ovf_full", bus.full_o, 1);
    check("ovf_flag", ovr, 1);
    check("ovf_irq", irq, 1);
    check("ovf_head", bus.rd_data_o, 8'h10);
    clr_ovr = 1'b1;
    cyc(1);
    clr_ovr = 1'b0;
    check("ovr_clr", ovr, 0);
    check("irq_thr16", irq, 1);
    bus.rd_en_i = 1'b1;
    send(8'h77, 1'b0);
    bus.rd_en_i = 1'b0;
    check("pp_count", bus.count_o, 16);
    check("pp_no_ovr", ovr, 0);
    check("pp_head", bus.rd_data_o, 8'h11);
    repeat (8) pop();
    check("drain8_count", bus.count_o, 8);
    check("drain8_head", bus.rd_data_o, 8'h19);
    cyc(1);
    check("rts_hold8", rts, 1);
    pop();
    cyc(1);
    check("rts_lo7", rts, 0);
    check("drain7_head", bus.rd_data_o, 8'h1a);
    repeat (6) pop();
    check("tail_head", bus.rd_data_o, 8'h77);
    check("tail_count", bus.count_o, 1);
    pop();
    check("drain_empty", bus.empty_o, 1);
    pop();
    check("underflow_ignored", bus.count_o, 0);
    thr = 5'd0;
    #1;
    check("thr0_empty_irq", irq, 0);
    clr_perr = 1'b1;
    send(8'h55, 1'b1);
    clr_perr = 1'b0;
    check("perr_set_wins", perr, 1);
    check("perr_head", bus.rd_perr_o, 1);
    check("perr_irq", irq, 1);
    clr_perr = 1'b1;
    cyc(1);
    clr_perr = 1'b0;
    check("perr_clr", perr, 0);
    check("thr0_as_1_irq", irq, 1);
    thr = 5'd2;
    #1;
    check("thr2_irq", irq, 0);
    tick = 1'b1;
    cyc(639);
    check("tmo_early", tmo, 0);
    cyc(1);
    tick = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
    check("tmo_set", tmo, 1);
    check("tmo_irq", irq, 1);
    pop();
    check("tmo_pop_clr", tmo, 0);
    check("tmo_pop_irq", irq, 0);
`else
    check("tmo_tied0", tmo, 0);
    pop();
    check("tmo_pop_irq", irq, 0);
`endif
    send(8'h61, 1'b1);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    check("pre_flush_count", bus.count_o, 3);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    bus.rx_done_i = 1'b1;
    bus.rx_data_i = 8'h64;
    cyc(1);
    bus.rx_done_i = 1'b0;
    check("flush_empty", bus.empty_o, 1);
    check("flush_count", bus.count_o, 0);
    check("flush_keeps_perr", perr, 1);
    send(8'h65, 1'b0);
    check("post_flush_head", bus.rd_data_o, 8'h65);
    check("post_flush_count", bus.count_o, 1);
    rx_en = 1'b0;
    cyc(1);
    send(8'h66, 1'b0);
    check("off_push_drop", bus.count_o, 1);
    pop();
    check("off_pop", bus.empty_o, 1);
    check("off_rts", rts, 1);
    rx_en = 1'b1;
    cyc(1);
    send(8'h70, 1'b0);
    send(8'h71, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_count", bus.count_o, 0);
    check("midrst_empty", bus.empty_o, 1);
    check("midrst_rts", rts, 1);
    check("midrst_perr", perr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
